// File: rtl/tt_rr_arb_pkg.sv
// rtl/tt_rr_arb_pkg.sv - shared constants and helpers for the round-robin one-hot arbiter
// Lock FSM encodings, index conversion and rotated priority mask generation.
package tt_rr_arb_pkg;

  localparam int MAX_REQ   = 32;
  localparam int MAX_IDX_W = $clog2(MAX_REQ);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

  // Bits at or above the pointer and below n: the first-priority half of the scan.
  function automatic logic [MAX_REQ-1:0] rr_mask(input int ptr, input int n);
    logic [MAX_REQ-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      m[i] = (i >= ptr) && (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/tt_rr_pick.sv
// rtl/tt_rr_pick.sv - combinational round-robin winner pick
// Double-request find-first: the masked copy sits in the low half so it wins over the wrap-around copy.
module tt_rr_pick
  import tt_rr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_win_oh,
  output logic [IDX_W-1:0]   o_win_idx
);

  logic [NUM_REQ-1:0]   w_mask;
  logic [NUM_REQ-1:0]   w_req_masked;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_dbl_low;

  always_comb begin
    w_mask       = NUM_REQ'(rr_mask(int'(i_ptr), NUM_REQ));
    w_req_masked = i_req & w_mask;
    w_dbl        = {i_req, w_req_masked};
    w_dbl_low    = w_dbl & (~w_dbl + 1'b1);
    o_win_oh     = w_dbl_low[NUM_REQ-1:0] | w_dbl_low[2*NUM_REQ-1:NUM_REQ];
    o_win_idx    = IDX_W'(onehot_to_idx(MAX_REQ'(o_win_oh)));
  end

endmodule

// File: rtl/tt_rr_onehot_arbiter.sv
// rtl/tt_rr_onehot_arbiter.sv - round-robin arbiter with packet lock and registered one-hot select
// Optional per-requester saturating grant counters under TT_RR_ARB_PERF_CNT_EN.
module tt_rr_onehot_arbiter
  import tt_rr_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ-1:0]   i_last,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic                 o_valid,
  output logic [NUM_REQ-1:0]   o_sel,
  output logic                 o_last,
  input  logic                 i_ready
`ifdef TT_RR_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ-1:0][CNT_WIDTH-1:0] o_grant_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || CNT_WIDTH < 1) begin : g_bad_param
    $error("tt_rr_onehot_arbiter: NUM_REQ must be 2..32 and CNT_WIDTH >= 1");
  end

  logic [0:0]         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_lock_idx;
  logic               r_valid;
  logic [NUM_REQ-1:0] r_sel;
  logic               r_last;

  logic [NUM_REQ-1:0] w_lock_oh;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_can_load;
  logic               w_load;
  logic               w_win_last;
  logic [IDX_W-1:0]   w_ptr_next;

  // While a packet is open only its owner is eligible; everyone else stalls.
  always_comb begin
    w_lock_oh = NUM_REQ'(1) << r_lock_idx;
    w_elig    = (r_state == ST_LOCKED) ? (i_req & w_lock_oh) : i_req;
  end

  tt_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req     (w_elig),
    .i_ptr     (r_ptr),
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx)
  );

  always_comb begin
    w_can_load = !r_valid || i_ready;
    w_load     = i_reset_n && w_can_load && (|w_elig);
    w_win_last = |(i_last & w_win_oh);
    w_ptr_next = (w_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
    o_ack      = w_load ? w_win_oh : '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= ST_UNLOCKED;
      r_ptr      <= '0;
      r_lock_idx <= '0;
      r_valid    <= 1'b0;
      r_sel      <= '0;
      r_last     <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_sel   <= w_win_oh;
      r_last  <= w_win_last;
      if (w_win_last) begin
        r_state <= ST_UNLOCKED;
        r_ptr   <= w_ptr_next;
      end else begin
        r_state    <= ST_LOCKED;
        r_lock_idx <= w_win_idx;
      end
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_last  <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_sel   = r_sel;
  assign o_last  = r_last;

`ifdef TT_RR_ARB_PERF_CNT_EN
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] r_grant_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_grant_cnt <= '0;
    end else if (w_load) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_win_oh[i] && (r_grant_cnt[i] != {CNT_WIDTH{1'b1}})) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign o_grant_cnt = r_grant_cnt;
`endif

endmodule
